// File: rtl/irrigation_timer_ctrl_pkg.sv
// irrigation_timer_ctrl_pkg: state encodings, BCD limits and mm:ss helpers for the irrigation timer
package irrigation_timer_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    localparam logic [2:0] SEC_TENS_MAX = 3'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [2:0] MIN_TENS_MAX = 3'd5;

    typedef struct packed {
        logic [2:0] min_t;
        logic [3:0] min_u;
        logic [2:0] sec_t;
        logic [3:0] sec_u;
    } mmss_t;

    function automatic logic preset_ok(input logic [2:0] t, input logic [3:0] u);
        return t <= MIN_TENS_MAX && u <= DIGIT_MAX && (t != 3'd0 || u != 4'd0);
    endfunction

    // One-second BCD decrement; each digit borrows only when all lower digits wrap.
    function automatic mmss_t bcd_dec(input mmss_t t);
        mmss_t r;
        logic b0, b1, b2;
        b0 = t.sec_u == 4'd0;
        b1 = b0 && t.sec_t == 3'd0;
        b2 = b1 && t.min_u == 4'd0;
        r.sec_u = b0 ? DIGIT_MAX : t.sec_u - 4'd1;
        r.sec_t = b0 ? (b1 ? SEC_TENS_MAX : t.sec_t - 3'd1) : t.sec_t;
        r.min_u = b1 ? (b2 ? DIGIT_MAX : t.min_u - 4'd1) : t.min_u;
        r.min_t = b2 ? t.min_t - 3'd1 : t.min_t;
        return r;
    endfunction
endpackage

// File: rtl/irrigation_timer_ctrl_tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV enabled cycles; hold freezes the phase without losing a due tick
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic hold,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    assign tick = enable && count == LAST;

    always_ff @(posedge clock or posedge reset)
        if (reset) count <= '0;
        else if (clear || tick) count <= '0;
        else if (enable && !hold) count <= count + 1'b1;
endmodule

// File: rtl/irrigation_timer_ctrl.sv
// irrigation_timer_ctrl: one irrigation cycle -- loads an mm:ss countdown, drives the valve, pause/resume/cancel
module irrigation_timer_ctrl
    import irrigation_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic [2:0] preset_tens,
    input  logic [3:0] preset_units,
    output logic       valve_on,
    output logic       busy,
    output logic       done,
    output logic [1:0] state,
    output logic [2:0] rem_min_t,
    output logic [3:0] rem_min_u,
    output logic [2:0] rem_sec_t,
    output logic [3:0] rem_sec_u
);
    state_t st;
    mmss_t  rem;
    mmss_t  nxt;
    logic   tick;
    logic   load;
    logic   pause_req;

    // start outranks pause, so a simultaneous start keeps RUN running
    assign pause_req = pause && !start;
    assign load      = (st == ST_IDLE || st == ST_DONE) && start && !cancel
                       && preset_ok(preset_tens, preset_units);
    assign nxt       = bcd_dec(rem);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .clock  (clock),
        .reset  (reset),
        .enable (st == ST_RUN),
        .hold   (pause_req),
        .clear  (cancel || load),
        .tick   (tick)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            st       <= ST_IDLE;
            rem      <= '0;
            done     <= 1'b0;
            valve_on <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                st       <= ST_IDLE;
                rem      <= '0;
                valve_on <= 1'b0;
                busy     <= 1'b0;
            end else if (load) begin
                st       <= ST_RUN;
                rem      <= {preset_tens, preset_units, 7'd0};
                valve_on <= 1'b1;
                busy     <= 1'b1;
            end else if (st == ST_RUN && tick) begin
                rem <= nxt;
                if (nxt == '0) begin
                    st       <= ST_DONE;
                    done     <= 1'b1;
                    valve_on <= 1'b0;
                    busy     <= 1'b0;
                end else if (pause_req) begin
                    st       <= ST_PAUSED;
                    valve_on <= 1'b0;
                end
            end else if (st == ST_RUN && pause_req) begin
                st       <= ST_PAUSED;
                valve_on <= 1'b0;
            end else if (st == ST_PAUSED && start) begin
                st       <= ST_RUN;
                valve_on <= 1'b1;
            end
        end

    assign state     = st;
    assign rem_min_t = rem.min_t;
    assign rem_min_u = rem.min_u;
    assign rem_sec_t = rem.sec_t;
    assign rem_sec_u = rem.sec_u;
endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// tb_irrigation_timer_ctrl: scoreboard bench for the irrigation timer with TICK_DIV=4
module tb_irrigation_timer_ctrl;
    localparam int IDLE = 0, RUN = 1, PAUSED = 2, DONE = 3;

    logic       clock = 1'b0;
    logic       reset, start, pause, cancel;
    logic [2:0] preset_tens;
    logic [3:0] preset_units;
    logic       valve_on, busy, done;
    logic [1:0] state;
    logic [2:0] rem_min_t, rem_sec_t;
    logic [3:0] rem_min_u, rem_sec_u;

    irrigation_timer_ctrl #(.TICK_DIV(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .cancel       (cancel),
        .preset_tens  (preset_tens),
        .preset_units (preset_units),
        .valve_on     (valve_on),
        .busy         (busy),
        .done         (done),
        .state        (state),
        .rem_min_t    (rem_min_t),
        .rem_min_u    (rem_min_u),
        .rem_sec_t    (rem_sec_t),
        .rem_sec_u    (rem_sec_u)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] st;
        logic       valve;
        logic       busy;
        logic       done;
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] s_t;
        logic [3:0] su;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } sb_t;

    typedef struct {
        logic [2:0] pt;
        logic [3:0] pu;
        obs_t       exp;
    } vec_t;

    sb_t  sb[$];
    vec_t vt[6];
    int   total = 0;
    int   bad = 0;
    int   dc, vc;

    function automatic obs_t mk(input int s, input int v, input int b, input int d, input int mm, input int ss);
        obs_t o;
        o.st    = 2'(s);
        o.valve = 1'(v);
        o.busy  = 1'(b);
        o.done  = 1'(d);
        o.mt    = 3'(mm / 10);
        o.mu    = 4'(mm % 10);
        o.s_t   = 3'(ss / 10);
        o.su    = 4'(ss % 10);
        return o;
    endfunction

    function automatic obs_t now_obs();
        return {state, valve_on, busy, done, rem_min_t, rem_min_u, rem_sec_t, rem_sec_u};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input string n, input obs_t e);
        sb.push_back('{n, e});
    endtask

    task automatic check_pop();
        sb_t r;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %h required an entry", now_obs());
        end else begin
            r = sb.pop_front();
            if (now_obs() !== r.exp) begin
                bad++;
                $display("FAIL %s: got %h required %h", r.name, now_obs(), r.exp);
            end
        end
    endtask

    task automatic expect_now(input string n, input obs_t e);
        push(n, e);
        check_pop();
    endtask

    task automatic expect_after(input string n, input obs_t e);
        push(n, e);
        step();
        check_pop();
    endtask

    task automatic check_int(input string n, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", n, got, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vt[0] = '{3'd6, 4'd0,  mk(IDLE, 0, 0, 0, 0, 0)};
        vt[1] = '{3'd0, 4'd10, mk(IDLE, 0, 0, 0, 0, 0)};
        vt[2] = '{3'd0, 4'd0,  mk(IDLE, 0, 0, 0, 0, 0)};
        vt[3] = '{3'd7, 4'd15, mk(IDLE, 0, 0, 0, 0, 0)};
        vt[4] = '{3'd5, 4'd9,  mk(RUN, 1, 1, 0, 59, 0)};
        vt[5] = '{3'd2, 4'd3,  mk(RUN, 1, 1, 0, 23, 0)};

        reset = 1'b1; start = 1'b0; pause = 1'b0; cancel = 1'b0;
        preset_tens = 3'd0; preset_units = 4'd0;
        step();
        expect_now("reset", mk(IDLE, 0, 0, 0, 0, 0));
        step();
        reset = 1'b0;
        step();

        preset_units = 4'd1; start = 1'b1;
        expect_after("load_01", mk(RUN, 1, 1, 0, 1, 0));
        start = 1'b0;
        preset_units = 4'd7;
        dc = 0;
        for (int k = 1; k <= 240; k++) begin
            step();
            if (k == 4) expect_now("tick1_0059", mk(RUN, 1, 1, 0, 0, 59));
            if (k < 240) dc += int'(done);
        end
        check_int("done_early", dc, 0);
        expect_now("done_0100", mk(DONE, 0, 0, 1, 0, 0));
        step();
        expect_now("done_hold", mk(DONE, 0, 0, 0, 0, 0));

        preset_tens = 3'd1; preset_units = 4'd0; start = 1'b1;
        expect_after("load_10", mk(RUN, 1, 1, 0, 10, 0));
        start = 1'b0;
        repeat (4) step();
        expect_now("borrow_0959", mk(RUN, 1, 1, 0, 9, 59));
        repeat (36) step();
        expect_now("tick10_0950", mk(RUN, 1, 1, 0, 9, 50));
        repeat (4) step();
        expect_now("sec_u_borrow_0949", mk(RUN, 1, 1, 0, 9, 49));
        repeat (196) step();
        expect_now("tick60_0900", mk(RUN, 1, 1, 0, 9, 0));
        repeat (4) step();
        expect_now("sec_t_borrow_0859", mk(RUN, 1, 1, 0, 8, 59));

        repeat (2) step();
        pause = 1'b1;
        expect_after("pause_enter", mk(PAUSED, 0, 1, 0, 8, 59));
        step();
        pause = 1'b0;
        vc = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            vc += int'(valve_on);
        end
        check_int("paused_valve", vc, 0);
        expect_now("paused_hold", mk(PAUSED, 0, 1, 0, 8, 59));
        start = 1'b1;
        expect_after("resume", mk(RUN, 1, 1, 0, 8, 59));
        start = 1'b0;
        step();
        expect_now("resume_plus1", mk(RUN, 1, 1, 0, 8, 59));
        step();
        expect_now("resume_plus2_tick", mk(RUN, 1, 1, 0, 8, 58));

        start = 1'b1;
        expect_after("start_in_run", mk(RUN, 1, 1, 0, 8, 58));
        cancel = 1'b1;
        expect_after("cancel_start", mk(IDLE, 0, 0, 0, 0, 0));
        start = 1'b0; cancel = 1'b0;

        for (int i = 0; i < 6; i++) begin
            preset_tens = vt[i].pt; preset_units = vt[i].pu; start = 1'b1;
            expect_after($sformatf("preset_vec%0d", i), vt[i].exp);
            start = 1'b0; cancel = 1'b1;
            step();
            cancel = 1'b0;
        end

        preset_tens = 3'd0; preset_units = 4'd1; start = 1'b1;
        expect_after("load_01b", mk(RUN, 1, 1, 0, 1, 0));
        start = 1'b0;
        repeat (239) step();
        expect_now("pre_final_0001", mk(RUN, 1, 1, 0, 0, 1));
        pause = 1'b1;
        expect_after("pause_final_done", mk(DONE, 0, 0, 1, 0, 0));
        pause = 1'b0;
        step();
        expect_now("final_done_once", mk(DONE, 0, 0, 0, 0, 0));

        preset_tens = 3'd6; preset_units = 4'd0; start = 1'b1;
        expect_after("done_bad_start", mk(DONE, 0, 0, 0, 0, 0));
        preset_tens = 3'd0; preset_units = 4'd2;
        expect_after("reload_02", mk(RUN, 1, 1, 0, 2, 0));
        start = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        #1;
        expect_now("reset_async", mk(IDLE, 0, 0, 0, 0, 0));
        step();
        reset = 1'b0;
        step();
        step();
        expect_now("after_reset_idle", mk(IDLE, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
